// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and presents one registered instruction to decode over valid/ready.
// Build option FETCH_ALIGN_CHECK_EN: a misaligned redirect target faults instead of being force-aligned.
module fetch_unit #(
   parameter int unsigned I_ADDR_W = 32'd12,
   parameter int unsigned INST_W   = 32'd16,
   parameter int unsigned RESET_PC = 32'd0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   output logic [I_ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0]   imem_instruction,
   input  logic                redirect_valid,
   input  logic [I_ADDR_W-1:0] redirect_target,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [INST_W-1:0]   out_instruction,
   output logic [I_ADDR_W-1:0] out_pc,
   output logic                fault
);

   localparam int unsigned         INST_BYTES = (INST_W + 32'd7) / 32'd8;
   localparam logic [I_ADDR_W-1:0] PC_STEP    = I_ADDR_W'(INST_BYTES);
   localparam logic [I_ADDR_W-1:0] PC_RESET   = I_ADDR_W'(RESET_PC);

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [0:0] {RUN = 1'b0, FAULT = 1'b1} state_t;
`else
   typedef enum logic [0:0] {RUN = 1'b0} state_t;
`endif

   // Byte offset of an address within its instruction slot.
   function automatic logic [I_ADDR_W-1:0] slot_offset(input logic [I_ADDR_W-1:0] addr);
      slot_offset = addr % PC_STEP;
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [I_ADDR_W-1:0] pc_r;
   logic [I_ADDR_W-1:0] pc_nxt_s;
   logic                valid_nxt_s;
   logic [INST_W-1:0]   inst_nxt_s;
   logic [I_ADDR_W-1:0] opc_nxt_s;
   logic [I_ADDR_W-1:0] aligned_target_s;
   logic                accept_s;
   logic                fire_s;

   assign imem_addr        = pc_r;
   assign aligned_target_s = redirect_target - slot_offset(redirect_target);
   assign accept_s         = out_valid & out_ready;
   assign fire_s           = (state_r == RUN) & en & ~redirect_valid & (~out_valid | out_ready);

`ifdef FETCH_ALIGN_CHECK_EN
   logic misaligned_s;
   logic fault_r;

   assign misaligned_s = (slot_offset(redirect_target) != '0);
   assign fault        = fault_r;

   // Sticky fault flag, set on the edge that enters FAULT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_r <= 1'b0;
      end else begin
         fault_r <= (state_nxt_s == FAULT);
      end
   end
`else
   assign fault = 1'b0;
`endif

   // Next-state logic: redirect beats fetch, fetch beats a plain drain, otherwise hold.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      valid_nxt_s = out_valid;
      inst_nxt_s  = out_instruction;
      opc_nxt_s   = out_pc;
      case (state_r)
         RUN: begin
            if (redirect_valid) begin
               // Flush even if decode also handshakes this cycle.
               valid_nxt_s = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
               if (misaligned_s) begin
                  state_nxt_s = FAULT;
               end else begin
                  pc_nxt_s = aligned_target_s;
               end
`else
               pc_nxt_s = aligned_target_s;
`endif
            end else if (fire_s) begin
               inst_nxt_s  = imem_instruction;
               opc_nxt_s   = pc_r;
               valid_nxt_s = 1'b1;
               pc_nxt_s    = pc_r + PC_STEP;
            end else if (accept_s) begin
               valid_nxt_s = 1'b0;
            end else begin
               valid_nxt_s = out_valid;
            end
         end
`ifdef FETCH_ALIGN_CHECK_EN
         FAULT: begin
            valid_nxt_s = 1'b0;
         end
`endif
         default: begin
            state_nxt_s = RUN;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State, PC and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= RUN;
         pc_r            <= PC_RESET;
         out_valid       <= 1'b0;
         out_instruction <= '0;
         out_pc          <= '0;
      end else begin
         state_r         <= state_nxt_s;
         pc_r            <= pc_nxt_s;
         out_valid       <= valid_nxt_s;
         out_instruction <= inst_nxt_s;
         out_pc          <= opc_nxt_s;
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of instruction_memory.
- Owns the program counter and drives the memory's combinational byte address.
- Registers the returned little-endian instruction, together with its PC, into an output register.
- Hands that register to decode over a valid/ready handshake. Supports branch redirect with flush, and a stall driven by backpressure or `en`.

Parameters:
- I_ADDR_W, 12: byte address width; matches instruction_memory.
- INST_W, 16: instruction width in bits.
- RESET_PC, 0: PC value loaded on reset; must be a multiple of INST_BYTES.
- INST_BYTES (localparam): (INST_W+7)/8; the PC increment.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  fetch enable; 0 suspends new fetches
- imem_addr  out  I_ADDR_W  byte address to instruction_memory
- imem_instruction  in  INST_W  instruction from instruction_memory, combinational on imem_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  I_ADDR_W  new PC when redirect_valid=1
- out_valid  out  1  output register holds a valid instruction
- out_ready  in  1  decode accepts the instruction this cycle
- out_instruction  out  INST_W  fetched instruction
- out_pc  out  I_ADDR_W  byte address of out_instruction
- fault  out  1  sticky fetch fault (optional feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - pc = RESET_PC
  - out_valid = 0
  - out_instruction = 0
  - out_pc = 0
  - fault = 0
  - state = RUN
- Address: imem_addr = pc directly from the register, with no extra logic. The instruction is sampled in the same cycle.
- States:
  - RUN: normal operation.
  - FAULT: entered only with the optional feature. Absorbing until reset.
- fire = (state==RUN) && en && !redirect_valid && (!out_valid || out_ready).
- On fire:
  - out_instruction <= imem_instruction
  - out_pc <= pc
  - out_valid <= 1
  - pc <= pc + INST_BYTES, modulo 2^I_ADDR_W; 0xFFE wraps to 0x000 at default widths.
- No fire, with out_valid && out_ready: out_valid <= 0.
- No fire, with out_valid && !out_ready: all output fields hold. Stable-until-accepted is mandatory.
- Redirect has top priority in RUN:
  - pc <= target (see optional feature for alignment).
  - out_valid <= 0. The held instruction is flushed even if out_ready=1 that cycle; decode must ignore a same-cycle handshake when it issues a redirect.
- Redirect timing: redirect_valid sampled at edge N gives pc=target after edge N. The target instruction appears with out_valid=1 after edge N+1, provided en=1 and there is no backpressure.
- Throughput: one instruction per cycle under continuous out_ready=1 and en=1.
- en=0: the PC holds. An already-valid output can still be consumed and then clears. Redirects are still honoured.
- Simultaneous redirect and en=0: redirect is applied and no fetch occurs.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). The first fetch is at RESET_PC after rst_n deasserts.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_target % INST_BYTES != 0 moves the block to FAULT on that edge.
  - In that cycle fault <= 1 and out_valid <= 0; pc is left unchanged.
  - In FAULT there are no further fetches, redirects are ignored, and fault stays at 1 until rst_n.
- Undefined:
  - No FAULT state; the fault port is tied to 0.
  - Misaligned targets are force-aligned by clearing the low log2(INST_BYTES) bits, so 0x105 loads pc = 0x104.

Test Plan:
1. Reset, then mem[0..5] = 34 12 78 56 BC 9A, en=1, out_ready=1 -> out_instruction 0x1234 @ out_pc 0x000, 0x5678 @ 0x002, 0x9ABC @ 0x004 on consecutive cycles, with out_valid continuously 1.
2. Backpressure: out_ready=0 for 3 cycles while out_valid=1 holding 0x5678 @ 0x002 -> outputs stable all 3 cycles and pc stays 0x004; on release, the next instruction is from 0x004.
3. Redirect: redirect_valid=1 with target 0x100 while out_valid=1 -> out_valid=0 the next cycle, then the instruction @ out_pc 0x100, with no instruction from the old stream in between.
4. Wrap: redirect to 0xFFE, mem[0xFFE]=0x11, mem[0xFFF]=0x22 -> out 0x2211 @ 0xFFE, then next out_pc is 0x000.
5. en toggle plus mid-run reset: en=0 for 2 cycles -> no new out_valid and pc frozen; then pulse rst_n low mid-stream -> out_valid=0 immediately, and fetch restarts at RESET_PC.
6. Redirect to 0x105: with FETCH_ALIGN_CHECK_EN -> fault=1 sticky and no further out_valid, even after a later redirect to 0x000. Without it -> fetch resumes at out_pc 0x104.
